// File: rtl/number_entry_pkg.sv
// Shared constants and FSM encoding for the operator number-entry block and the display path.
// Both sides use the same digit count so the edit buffer lines up with the display digits.
package number_entry_pkg;

    localparam int          W_DEF    = 16;
    localparam int          NDIG_DEF = 5;
    localparam logic [3:0]  BCD_MAX  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // One BCD step with wrap-around: 9+1 -> 0 and 0-1 -> 9.
    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic inc);
        if (inc)
            return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
        else
            return (d == 4'd0) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/number_entry_bcd_to_bin_seq.sv
// Sequential BCD to two's-complement converter: Horner accumulation MSD first, one digit per cycle,
// then a range check and signed result update on the finish strobe.
module bcd_to_bin_seq
    import number_entry_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NDIG = NDIG_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_fin,
    input  logic [4*NDIG-1:0] i_bcd,
    input  logic              i_sign,
    output logic              o_last,
    output logic              o_done,
    output logic              o_err,
    output logic [W-1:0]      o_result
);

    localparam int AW = W + 1;
    localparam logic [AW-1:0] NEG_LIM = {{(AW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [AW-1:0] POS_LIM = NEG_LIM - {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] r_acc;
    logic [2:0]    r_idx;
    logic          r_run;
    logic          r_done;
    logic          r_err;
    logic [W-1:0]  r_result;

    logic [3:0]    w_digit;
    logic [AW-1:0] w_acc_next;
    logic [AW-1:0] w_limit;
    logic [AW-1:0] w_neg;

    assign w_digit    = i_bcd[{r_idx, 2'b00} +: 4];
    // acc*10 as shift-and-add; no multiplier needed.
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {{(AW-4){1'b0}}, w_digit};
    assign w_limit    = i_sign ? NEG_LIM : POS_LIM;
    assign w_neg      = {AW{1'b0}} - r_acc;
    assign o_last     = r_run && (r_idx == 3'd0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_acc    <= '0;
            r_idx    <= '0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_acc <= '0;
                r_idx <= 3'(NDIG - 1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx - 3'd1;
                if (r_idx == 3'd0)
                    r_run <= 1'b0;
            end
            if (i_fin) begin
                r_done <= 1'b1;
                if (r_acc > w_limit) begin
                    r_err <= 1'b1;
                end else begin
                    r_err    <= 1'b0;
                    r_result <= i_sign ? w_neg[W-1:0] : r_acc[W-1:0];
                end
            end
        end
    end

    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_result = r_result;

endmodule

// File: rtl/number_entry.sv
// Operator number entry: cursor/digit/sign edit buffer driven by button pulses, and an
// enter-triggered conversion of the buffer into a signed binary word.
module number_entry
    import number_entry_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NDIG = NDIG_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_l,
    input  logic              i_r,
    input  logic              i_up,
    input  logic              i_dn,
    input  logic              i_sgn,
    input  logic              i_clr,
    input  logic              i_enter,
    output logic [4*NDIG-1:0] o_digits,
    output logic              o_sign,
    output logic [2:0]        o_cursor,
    output logic              o_busy,
    output logic [W-1:0]      o_binary,
    output logic              o_valid,
    output logic              o_err,
    output state_t            o_state
);

    state_t r_state;
    state_t w_state_next;

    logic [4*NDIG-1:0] r_digits;
    logic              r_sign;
    logic [2:0]        r_cursor;

    logic       w_busy;
    logic       w_start;
    logic       w_fin;
    logic       w_last;
    logic       w_edit;
    logic [3:0] w_cur_digit;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_enter) w_state_next = ST_CONV;
            ST_CONV: if (w_last)  w_state_next = ST_FIN;
            ST_FIN:               w_state_next = ST_IDLE;
            default:              w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state != ST_IDLE);
        w_start = (r_state == ST_IDLE) && i_enter;
        w_fin   = (r_state == ST_FIN);
        // Edits are only taken in IDLE, and an enter in the same cycle wins over them.
        w_edit  = (r_state == ST_IDLE) && !i_enter;
    end

    assign w_cur_digit = r_digits[{r_cursor, 2'b00} +: 4];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_digits <= '0;
            r_sign   <= 1'b0;
            r_cursor <= '0;
        end else if (w_edit) begin
            if (i_l && !i_r && (r_cursor != 3'(NDIG - 1)))
                r_cursor <= r_cursor + 3'd1;
            else if (i_r && !i_l && (r_cursor != 3'd0))
                r_cursor <= r_cursor - 3'd1;

            if (i_clr) begin
                r_digits <= '0;
                r_sign   <= 1'b0;
            end else begin
                if (i_up != i_dn)
                    r_digits[{r_cursor, 2'b00} +: 4] <= bcd_step(w_cur_digit, i_up);
                if (i_sgn)
                    r_sign <= ~r_sign;
            end
        end
    end

    bcd_to_bin_seq #(
        .W    (W),
        .NDIG (NDIG)
    ) u_conv (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_start),
        .i_fin    (w_fin),
        .i_bcd    (r_digits),
        .i_sign   (r_sign),
        .o_last   (w_last),
        .o_done   (o_valid),
        .o_err    (o_err),
        .o_result (o_binary)
    );

    assign o_digits = r_digits;
    assign o_sign   = r_sign;
    assign o_cursor = r_cursor;
    assign o_busy   = w_busy;
    assign o_state  = r_state;

endmodule

// File: tb/tb_number_entry.sv
// Directed bench for number_entry: editing, conversion timing, range limits, input dropping while busy,
// and reset in the middle of a conversion.
module tb_number_entry;
    import number_entry_pkg::*;

    logic        clk;
    logic        rst;
    logic        l, r, up, dn, sgn, clr, enter;
    logic [19:0] digits;
    logic        sign;
    logic [2:0]  cursor;
    logic        busy;
    logic [15:0] binary;
    logic        valid;
    logic        err;
    state_t      state;

    int tests;
    int fails;

    number_entry dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_l      (l),
        .i_r      (r),
        .i_up     (up),
        .i_dn     (dn),
        .i_sgn    (sgn),
        .i_clr    (clr),
        .i_enter  (enter),
        .o_digits (digits),
        .o_sign   (sign),
        .o_cursor (cursor),
        .o_busy   (busy),
        .o_binary (binary),
        .o_valid  (valid),
        .o_err    (err),
        .o_state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit order of m: {enter, clr, sgn, dn, up, r, l}; held for exactly one sampling edge.
    task automatic press(input logic [6:0] m);
        {enter, clr, sgn, dn, up, r, l} = m;
        tick();
        {enter, clr, sgn, dn, up, r, l} = 7'b0;
    endtask

    localparam logic [6:0] P_L = 7'b0000001, P_R = 7'b0000010, P_UP = 7'b0000100,
                           P_DN = 7'b0001000, P_SGN = 7'b0010000, P_CLR = 7'b0100000,
                           P_ENT = 7'b1000000;

    // Clear, walk the cursor from ones to MSD setting each digit, then apply the sign.
    task automatic load(input logic [19:0] bcd, input logic s);
        logic [3:0] nib;
        press(P_CLR);
        for (int i = 0; i < 5; i++) press(P_R);
        for (int p = 0; p < 5; p++) begin
            nib = bcd[4*p +: 4];
            for (int j = 0; j < int'(nib); j++) press(P_UP);
            press(P_L);
        end
        if (s) press(P_SGN);
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        tests++; if (digits !== 20'h0) begin fails++; $display("FAIL reset_digits: got %h want 00000", digits); end
        tests++; if (sign !== 1'b0) begin fails++; $display("FAIL reset_sign: got %b want 0", sign); end
        tests++; if (cursor !== 3'd0) begin fails++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
        tests++; if (busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL reset_flags: busy=%b valid=%b err=%b want 000", busy, valid, err); end
        tests++; if (binary !== 16'h0) begin fails++; $display("FAIL reset_binary: got %h want 0000", binary); end
        tests++; if (state !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", state); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_conv();
        int nb, nv;
        load(20'h12345, 1'b0);
        tests++; if (digits !== 20'h12345) begin fails++; $display("FAIL basic_digits: got %h want 12345", digits); end
        press(P_ENT);
        nb = 0; nv = 0;
        while (busy && nb < 20) begin
            nb++;
            if (valid) nv++;
            tick();
        end
        tests++; if (nb != 6) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 6", nb); end
        tests++; if (nv != 0) begin fails++; $display("FAIL basic_early_valid: got %0d want 0", nv); end
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL basic_valid_k6: got %b want 1", valid); end
        tests++; if (binary !== 16'h3039 || err !== 1'b0) begin
            fails++; $display("FAIL basic_result: got %h err=%b want 3039 err=0", binary, err); end
        tick();
        tests++; if (valid !== 1'b0 || binary !== 16'h3039) begin
            fails++; $display("FAIL basic_after: valid=%b bin=%h want 0 3039", valid, binary); end
    endtask

    task automatic test_range();
        bit got;
        load(20'h32768, 1'b1);
        press(P_ENT);
        wait_valid(got);
        tests++; if (!got || binary !== 16'h8000 || err !== 1'b0) begin
            fails++; $display("FAIL range_neg_min: got=%b bin=%h err=%b want 1 8000 0", got, binary, err); end
        press(P_SGN);
        press(P_ENT);
        wait_valid(got);
        tests++; if (!got || err !== 1'b1 || binary !== 16'h8000) begin
            fails++; $display("FAIL range_pos_over: got=%b bin=%h err=%b want 1 8000 1", got, binary, err); end
        tick();
        tests++; if (valid !== 1'b0 || err !== 1'b1) begin
            fails++; $display("FAIL range_err_hold: valid=%b err=%b want 0 1", valid, err); end
        load(20'h32767, 1'b0);
        press(P_ENT);
        wait_valid(got);
        tests++; if (!got || binary !== 16'h7fff || err !== 1'b0) begin
            fails++; $display("FAIL range_pos_max: got=%b bin=%h err=%b want 1 7fff 0", got, binary, err); end
        load(20'h32769, 1'b1);
        press(P_ENT);
        wait_valid(got);
        tests++; if (!got || binary !== 16'h7fff || err !== 1'b1) begin
            fails++; $display("FAIL range_neg_over: got=%b bin=%h err=%b want 1 7fff 1", got, binary, err); end
    endtask

    task automatic test_cursor_digits();
        press(P_CLR);
        for (int i = 0; i < 5; i++) press(P_R);
        press(P_R);
        tests++; if (cursor !== 3'd0) begin fails++; $display("FAIL cursor_sat_low: got %0d want 0", cursor); end
        for (int i = 0; i < 6; i++) press(P_L);
        tests++; if (cursor !== 3'd4) begin fails++; $display("FAIL cursor_sat_high: got %0d want 4", cursor); end
        press(P_L | P_R);
        tests++; if (cursor !== 3'd4) begin fails++; $display("FAIL cursor_lr: got %0d want 4", cursor); end
        press(P_DN);
        tests++; if (digits !== 20'h90000) begin fails++; $display("FAIL digit_dn_wrap: got %h want 90000", digits); end
        press(P_UP);
        tests++; if (digits !== 20'h00000) begin fails++; $display("FAIL digit_up_wrap: got %h want 00000", digits); end
        press(P_DN);
        press(P_UP | P_DN);
        tests++; if (digits !== 20'h90000) begin fails++; $display("FAIL digit_updn: got %h want 90000", digits); end
        press(P_R);
        press(P_UP);
        tests++; if (digits !== 20'h91000 || cursor !== 3'd3) begin
            fails++; $display("FAIL digit_other: got %h cur=%0d want 91000 3", digits, cursor); end
    endtask

    task automatic test_neg_zero_clr();
        bit got;
        press(P_CLR);
        press(P_SGN);
        tests++; if (sign !== 1'b1) begin fails++; $display("FAIL sgn_toggle: got %b want 1", sign); end
        press(P_ENT);
        wait_valid(got);
        tests++; if (!got || binary !== 16'h0 || err !== 1'b0) begin
            fails++; $display("FAIL neg_zero: got=%b bin=%h err=%b want 1 0000 0", got, binary, err); end
        press(P_UP);
        press(P_CLR | P_SGN | P_UP);
        tests++; if (sign !== 1'b0 || digits !== 20'h0) begin
            fails++; $display("FAIL clr_priority: sign=%b dig=%h want 0 00000", sign, digits); end
    endtask

    task automatic test_busy_drop();
        int nv;
        load(20'h00042, 1'b0);
        press(P_ENT);
        press(P_UP);
        press(P_L | P_R);
        press(P_R);
        press(P_ENT);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid) nv++;
        end
        tests++; if (nv != 1) begin fails++; $display("FAIL busy_valid_count: got %0d want 1", nv); end
        tests++; if (digits !== 20'h00042 || cursor !== 3'd4) begin
            fails++; $display("FAIL busy_frozen: dig=%h cur=%0d want 00042 4", digits, cursor); end
        tests++; if (binary !== 16'h002a) begin fails++; $display("FAIL busy_result: got %h want 002a", binary); end
    endtask

    task automatic test_fin_enter();
        int nv;
        press(P_ENT);
        for (int i = 0; i < 5; i++) tick();
        tests++; if (state !== ST_FIN) begin fails++; $display("FAIL fin_state: got %0d want FIN", state); end
        press(P_ENT);
        nv = valid ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid) nv++;
        end
        tests++; if (nv != 1 || busy !== 1'b0) begin
            fails++; $display("FAIL fin_enter_drop: valids=%0d busy=%b want 1 0", nv, busy); end
    endtask

    task automatic test_reset_mid();
        int nv;
        load(20'h00007, 1'b0);
        press(P_ENT);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++; if (busy !== 1'b0 || binary !== 16'h0 || digits !== 20'h0 || state !== ST_IDLE) begin
            fails++; $display("FAIL reset_mid: busy=%b bin=%h dig=%h st=%0d want 0 0000 00000 IDLE",
                              busy, binary, digits, state); end
        rst = 1'b1;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid) nv++;
        end
        tests++; if (nv != 0) begin fails++; $display("FAIL reset_mid_valid: got %0d want 0", nv); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        {enter, clr, sgn, dn, up, r, l} = 7'b0;
        test_reset();
        test_basic_conv();
        test_range();
        test_cursor_digits();
        test_neg_zero_clr();
        test_busy_drop();
        test_fin_enter();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
